// File: rtl/sm_display_pkg.sv
// Shared constants for the seven-segment scan driver: segment LUT,
// the "all segments dark" pattern and the PWM phase width.
package sm_display_pkg;

  // Brightness/phase resolution: the top PWM_W bits of the slot counter
  // form the PWM phase compared against the brightness level.
  localparam int PWM_W = 4;

  // Active-high "nothing lit" segment pattern (gfedcba).
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Hex glyphs, active-high, bit order gfedcba. Entry n is SEG_LUT[n].
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  // Nibble to glyph lookup.
  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/sm_hex_to_seg.sv
// Combinational hex nibble to seven-segment (gfedcba, active-high) decoder.
module sm_hex_to_seg
  import sm_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure table lookup; polarity is applied by the caller.
  always_comb begin
    seg = hex_seg(nibble);
  end

endmodule

// File: rtl/sm_hex_display_scan.sv
// Multiplexed hex display scanner: frame-synchronous value handover,
// inter-digit ghost blanking, leading-zero blanking and 16-level PWM.
module sm_hex_display_scan
  import sm_display_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int PRESCALE     = 16,   // slot = 2**PRESCALE cycles, >= 6
  parameter int BLANK_CYCLES = 64,   // < 2**(PRESCALE-4)
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] value,
  input  logic                valueValid,
  input  logic [DIGITS-1:0]   dpMask,
  input  logic                lzbEnable,
  input  logic [PWM_W-1:0]    brightness,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [DIGITS-1:0]   anode,
  output logic                frameDone
);

  localparam int                 IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [PRESCALE-1:0] BLANK_END = PRESCALE'(BLANK_CYCLES);

  // Output polarity masks: XOR with these turns active-high into board polarity.
  localparam logic [6:0]        SEG_POL = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_POL  = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic              DP_POL  = ACTIVE_LOW;

  // Scan position
  logic [PRESCALE-1:0] slot_cnt;
  logic [IDX_W-1:0]    digit_idx;
  logic                slot_end;
  logic                frame_end;

  // Pending (captured) and shown (frame-stable) display contents
  logic [DIGITS-1:0][3:0] pend_val;
  logic [DIGITS-1:0]      pend_dp;
  logic                   pend_flag;
  logic [DIGITS-1:0][3:0] shown_val;
  logic [DIGITS-1:0]      shown_dp;

  // Per-cycle lit evaluation
  logic [DIGITS-1:0] zero_above;   // nibbles i..DIGITS-1 all zero
  logic [3:0]        cur_nib;
  logic [6:0]        cur_seg;
  logic [PWM_W-1:0]  phase;
  logic              blanked;
  logic              lit;

  assign slot_end  = &slot_cnt;
  assign frame_end = slot_end && (digit_idx == LAST_IDX);

  // Slot counter free-runs; digit index advances when a slot wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      slot_cnt <= slot_cnt + PRESCALE'(1);
      if (slot_end)
        digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + IDX_W'(1);
    end
  end

  // Capture data path; validity is tracked by pend_flag, so no reset needed.
  always_ff @(posedge clk) begin
    if (valueValid) begin
      pend_val <= value;
      pend_dp  <= dpMask;
    end
  end

  // Pending flag and frame-boundary handover. A capture on the boundary
  // cycle itself goes straight to the shown copy and supersedes any pending one.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_flag <= 1'b0;
      shown_val <= '0;
      shown_dp  <= '0;
    end else if (frame_end) begin
      if (valueValid) begin
        shown_val <= value;
        shown_dp  <= dpMask;
        pend_flag <= 1'b0;
      end else if (pend_flag) begin
        shown_val <= pend_val;
        shown_dp  <= pend_dp;
        pend_flag <= 1'b0;
      end
    end else if (valueValid) begin
      pend_flag <= 1'b1;
    end
  end

  // Suffix-AND of "nibble is zero", from the most significant digit down.
  always_comb begin
    zero_above = '0;
    zero_above[DIGITS-1] = (shown_val[DIGITS-1] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--)
      zero_above[i] = (shown_val[i] == 4'h0) && zero_above[i+1];
  end

  // Lit decision: past the ghost-blank window, inside the PWM on-time,
  // and not a suppressed leading zero (digit 0 always shows).
  always_comb begin
    cur_nib = shown_val[digit_idx];
    phase   = slot_cnt[PRESCALE-1 -: PWM_W];
    blanked = lzbEnable && (digit_idx != '0) && zero_above[digit_idx];
    lit     = (slot_cnt >= BLANK_END) && (phase <= brightness) && !blanked;
  end

  sm_hex_to_seg u_dec (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  // Registered pad outputs in board polarity; reset drives everything dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      anode     <= AN_POL;
      seg       <= SEG_OFF ^ SEG_POL;
      dp        <= DP_POL;
      frameDone <= 1'b0;
    end else begin
      frameDone <= frame_end;
      if (lit) begin
        anode <= (DIGITS'(1) << digit_idx) ^ AN_POL;
        seg   <= cur_seg ^ SEG_POL;
        dp    <= shown_dp[digit_idx] ^ DP_POL;
      end else begin
        anode <= AN_POL;
        seg   <= SEG_OFF ^ SEG_POL;
        dp    <= DP_POL;
      end
    end
  end

endmodule

// File: tb/tb_sm_hex_display_scan.sv
// Scoreboard bench for sm_hex_display_scan with an 8-digit, 64-cycle-slot
// configuration (frame = 512 cycles), active-high outputs.
module tb_sm_hex_display_scan;

  typedef struct packed {
    logic [7:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] value = '0;
  logic        valueValid = 1'b0;
  logic [7:0]  dpMask = '0;
  logic        lzbEnable = 1'b0;
  logic [3:0]  brightness = 4'hF;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  anode;
  logic        frameDone;

  int vec  = 0;
  int miss = 0;

  // Bench-side view of the display: edges since reset release and
  // the value the spec says must be on screen.
  int          k = 0;
  int          last_k = 0;
  logic [31:0] m_shown = '0;
  logic [7:0]  m_dp = '0;
  logic [31:0] m_pend = '0;
  logic [7:0]  m_pdp = '0;
  logic        m_flag = 1'b0;
  outs_t       sb[$];

  logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  sm_hex_display_scan #(
    .DIGITS(8), .PRESCALE(6), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .valueValid(valueValid),
    .dpMask(dpMask), .lzbEnable(lzbEnable), .brightness(brightness),
    .seg(seg), .dp(dp), .anode(anode), .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  function automatic outs_t got();
    outs_t o;
    o.anode = anode; o.seg = seg; o.dp = dp; o.fd = frameDone;
    return o;
  endfunction

  // Expected outputs registered at edge kk (kk counted from reset release).
  function automatic outs_t exp_out(int kk, logic [31:0] v, logic [7:0] dm,
                                    logic lzb, logic [3:0] br);
    outs_t o;
    int slot, d;
    logic [3:0] nib;
    logic blank;
    slot = kk % 64;
    d = (kk / 64) % 8;
    o = '0;
    o.fd = (kk % 512 == 511);
    nib = v[4*d +: 4];
    blank = lzb && (d > 0) && ((v >> (4*d)) == 32'h0);
    if (slot >= 2 && (slot / 4) <= int'(br) && !blank) begin
      o.anode = 8'h01 << d;
      o.seg   = segtab[nib];
      o.dp    = dm[d];
    end
    return o;
  endfunction

  // Push the expectation for the coming edge, advance the bench view, clock once.
  task automatic step();
    outs_t e;
    if (rst) e = '0;
    else     e = exp_out(k, m_shown, m_dp, lzbEnable, brightness);
    sb.push_back(e);
    last_k = k;
    if (rst) begin
      k = 0; m_shown = '0; m_dp = '0; m_flag = 1'b0;
    end else begin
      if (k % 512 == 511) begin
        if (valueValid) begin
          m_shown = value; m_dp = dpMask; m_flag = 1'b0;
        end else if (m_flag) begin
          m_shown = m_pend; m_dp = m_pdp; m_flag = 1'b0;
        end
      end else if (valueValid) begin
        m_pend = value; m_pdp = dpMask; m_flag = 1'b1;
      end
      k++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    outs_t e;
    int first_fd;
    first_fd = -1;
    rst = 1'b1;
    repeat (3) begin
      step(); e = sb.pop_front(); vec++;
      if (got() !== e) begin miss++; $display("FAIL reset_hold k=%0d got=%h want=%h", last_k, got(), e); end
    end
    rst = 1'b0;
    repeat (520) begin
      step(); e = sb.pop_front(); vec++;
      if (got() !== e) begin miss++; $display("FAIL reset_scan k=%0d got=%h want=%h", last_k, got(), e); end
      if (last_k == 2) begin
        vec++;
        if (anode !== 8'h01 || seg !== 7'h3F) begin
          miss++; $display("FAIL first_lit anode=%h seg=%h want 01/3f", anode, seg);
        end
      end
      if (frameDone === 1'b1 && first_fd < 0) first_fd = last_k;
    end
    vec++;
    if (first_fd != 511) begin miss++; $display("FAIL first_frame_done at=%0d want 511", first_fd); end
  endtask

  task automatic test_tear_free();
    outs_t e;
    int nf;
    while (k % 512 != 200) begin
      step(); e = sb.pop_front(); vec++;
      if (got() !== e) begin miss++; $display("FAIL tear_pre k=%0d got=%h want=%h", last_k, got(), e); end
    end
    value = 32'h12345678; dpMask = 8'h81; valueValid = 1'b1; nf = k / 512 + 1;
    step(); e = sb.pop_front(); vec++;
    if (got() !== e) begin miss++; $display("FAIL tear_cap k=%0d got=%h want=%h", last_k, got(), e); end
    valueValid = 1'b0; value = '0; dpMask = '0;
    while (k < (nf + 1) * 512) begin
      step(); e = sb.pop_front(); vec++;
      if (got() !== e) begin miss++; $display("FAIL tear_scan k=%0d got=%h want=%h", last_k, got(), e); end
      if (last_k == (nf - 1) * 512 + 7 * 64 + 10) begin
        vec++;
        if (anode !== 8'h80 || seg !== 7'h3F || dp !== 1'b0) begin
          miss++; $display("FAIL tear_old_d7 anode=%h seg=%h dp=%b want 80/3f/0", anode, seg, dp);
        end
      end
      if (last_k == nf * 512 + 10) begin
        vec++;
        if (anode !== 8'h01 || seg !== 7'h7F || dp !== 1'b1) begin
          miss++; $display("FAIL tear_new_d0 anode=%h seg=%h dp=%b want 01/7f/1", anode, seg, dp);
        end
      end
      if (last_k == nf * 512 + 7 * 64 + 10) begin
        vec++;
        if (anode !== 8'h80 || seg !== 7'h06 || dp !== 1'b1) begin
          miss++; $display("FAIL tear_new_d7 anode=%h seg=%h dp=%b want 80/06/1", anode, seg, dp);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    outs_t e;
    int nf;
    while (k % 512 != 100) begin
      step(); e = sb.pop_front(); vec++;
      if (got() !== e) begin miss++; $display("FAIL simul_pre k=%0d got=%h want=%h", last_k, got(), e); end
    end
    value = 32'hAAAAAAAA; valueValid = 1'b1;
    step(); e = sb.pop_front(); vec++;
    if (got() !== e) begin miss++; $display("FAIL simul_pend k=%0d got=%h want=%h", last_k, got(), e); end
    valueValid = 1'b0;
    while (k % 512 != 511) begin
      step(); e = sb.pop_front(); vec++;
      if (got() !== e) begin miss++; $display("FAIL simul_wait k=%0d got=%h want=%h", last_k, got(), e); end
    end
    value = 32'h0000BEEF; valueValid = 1'b1; nf = k / 512 + 1;
    step(); e = sb.pop_front(); vec++;
    if (got() !== e) begin miss++; $display("FAIL simul_edge k=%0d got=%h want=%h", last_k, got(), e); end
    valueValid = 1'b0; value = '0;
    while (k < (nf + 2) * 512) begin
      step(); e = sb.pop_front(); vec++;
      if (got() !== e) begin miss++; $display("FAIL simul_scan k=%0d got=%h want=%h", last_k, got(), e); end
      if (last_k == nf * 512 + 10) begin
        vec++;
        if (anode !== 8'h01 || seg !== 7'h71) begin
          miss++; $display("FAIL simul_d0 anode=%h seg=%h want 01/71", anode, seg);
        end
      end
      if (last_k == (nf + 1) * 512 + 3 * 64 + 10) begin
        vec++;
        if (anode !== 8'h08 || seg !== 7'h7C) begin
          miss++; $display("FAIL simul_flag_clr anode=%h seg=%h want 08/7c", anode, seg);
        end
      end
    end
  endtask

  task automatic test_lzb();
    outs_t e;
    int nf;
    logic [7:0] seen_on, seen_off;
    seen_on = '0; seen_off = '0;
    while (k % 512 != 50) begin
      step(); e = sb.pop_front(); vec++;
      if (got() !== e) begin miss++; $display("FAIL lzb_pre k=%0d got=%h want=%h", last_k, got(), e); end
    end
    value = 32'h00000F00; valueValid = 1'b1; lzbEnable = 1'b1; nf = k / 512 + 1;
    step(); e = sb.pop_front(); vec++;
    if (got() !== e) begin miss++; $display("FAIL lzb_cap k=%0d got=%h want=%h", last_k, got(), e); end
    valueValid = 1'b0;
    while (k < (nf + 2) * 512) begin
      if (k == (nf + 1) * 512) lzbEnable = 1'b0;
      step(); e = sb.pop_front(); vec++;
      if (got() !== e) begin miss++; $display("FAIL lzb_scan k=%0d got=%h want=%h", last_k, got(), e); end
      if (last_k / 512 == nf) seen_on = seen_on | anode;
      else if (last_k / 512 == nf + 1) seen_off = seen_off | anode;
      if (last_k == nf * 512 + 10 || last_k == nf * 512 + 64 + 10) begin
        vec++;
        if (seg !== 7'h3F) begin miss++; $display("FAIL lzb_low_zero k=%0d seg=%h want 3f", last_k, seg); end
      end
      if (last_k == nf * 512 + 128 + 10) begin
        vec++;
        if (anode !== 8'h04 || seg !== 7'h71) begin
          miss++; $display("FAIL lzb_d2 anode=%h seg=%h want 04/71", anode, seg);
        end
      end
    end
    vec++;
    if (seen_on !== 8'h07) begin miss++; $display("FAIL lzb_on_digits got=%h want 07", seen_on); end
    vec++;
    if (seen_off !== 8'hFF) begin miss++; $display("FAIL lzb_off_digits got=%h want ff", seen_off); end
  endtask

  task automatic test_brightness();
    outs_t e;
    int cnt;
    brightness = 4'h0; cnt = 0;
    repeat (512) begin
      step(); e = sb.pop_front(); vec++;
      if (got() !== e) begin miss++; $display("FAIL bright0 k=%0d got=%h want=%h", last_k, got(), e); end
      if (anode !== 8'h00) cnt++;
    end
    vec++;
    if (cnt != 16) begin miss++; $display("FAIL bright0_on_cycles got=%0d want 16", cnt); end
    brightness = 4'hF; cnt = 0;
    repeat (512) begin
      step(); e = sb.pop_front(); vec++;
      if (got() !== e) begin miss++; $display("FAIL bright15 k=%0d got=%h want=%h", last_k, got(), e); end
      if (anode !== 8'h00) cnt++;
    end
    vec++;
    if (cnt != 496) begin miss++; $display("FAIL bright15_on_cycles got=%0d want 496", cnt); end
  endtask

  task automatic test_reset_mid();
    outs_t e;
    while (k % 512 != 4 * 64 + 20) begin
      step(); e = sb.pop_front(); vec++;
      if (got() !== e) begin miss++; $display("FAIL rmid_pre k=%0d got=%h want=%h", last_k, got(), e); end
    end
    value = 32'hDEADBEEF; dpMask = 8'hFF; valueValid = 1'b1;
    step(); e = sb.pop_front(); vec++;
    if (got() !== e) begin miss++; $display("FAIL rmid_cap k=%0d got=%h want=%h", last_k, got(), e); end
    valueValid = 1'b0; value = '0; dpMask = '0;
    repeat (5) begin
      step(); e = sb.pop_front(); vec++;
      if (got() !== e) begin miss++; $display("FAIL rmid_run k=%0d got=%h want=%h", last_k, got(), e); end
    end
    rst = 1'b1;
    step(); e = sb.pop_front(); vec++;
    if (anode !== 8'h00 || seg !== 7'h00 || dp !== 1'b0 || frameDone !== 1'b0) begin
      miss++; $display("FAIL rmid_dark got=%h want 0", got());
    end
    rst = 1'b0;
    repeat (1100) begin
      step(); e = sb.pop_front(); vec++;
      if (got() !== e) begin miss++; $display("FAIL rmid_scan k=%0d got=%h want=%h", last_k, got(), e); end
      if (last_k == 2) begin
        vec++;
        if (anode !== 8'h01 || seg !== 7'h3F || dp !== 1'b0) begin
          miss++; $display("FAIL rmid_restart anode=%h seg=%h dp=%b want 01/3f/0", anode, seg, dp);
        end
      end
      if (last_k == 512 + 3 * 64 + 10) begin
        vec++;
        if (anode !== 8'h08 || seg !== 7'h3F || dp !== 1'b0) begin
          miss++; $display("FAIL rmid_discard anode=%h seg=%h dp=%b want 08/3f/0", anode, seg, dp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_tear_free();
    test_simultaneous();
    test_lzb();
    test_brightness();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
